// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: state encoding, register width,
// feedback taps and the single-step update function.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;

    // Taps at bits 15, 13, 12 and 10: x^16 + x^14 + x^13 + x^11 + 1, period 65535.
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

    typedef enum logic [1:0] {
        GEN,
        HOLD,
        SHAKE
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running 16-bit Fibonacci LFSR with a valid/ready word output and a
// reseed handshake towards the shaker stage.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned        STEPS_PER_WORD = 1,
    parameter int unsigned        SHK_TIMEOUT    = 1024,
    parameter logic [LFSR_W-1:0]  SEED_DEFAULT   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_shk,
    output logic              s_shk,
    output logic [LFSR_W-1:0] curr_lfsr,
    input  logic              shk_end,
    input  logic [LFSR_W-1:0] shk_lfsr,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [LFSR_W-1:0] rnd_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [3:0]  STEP_LAST = 4'(STEPS_PER_WORD - 1);
    localparam logic [15:0] TMO_LAST  = 16'(SHK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [3:0]        step_cnt_q, step_cnt_d;
    logic              pend_q, pend_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic              s_shk_q, s_shk_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic [LFSR_W-1:0] rnd_data_q, rnd_data_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic              enter_shake;
    logic              exit_shake;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        step_cnt_d    = step_cnt_q;
        pend_d        = pend_q;
        tmo_cnt_d     = tmo_cnt_q;
        s_shk_d       = s_shk_q;
        rnd_valid_d   = rnd_valid_q;
        rnd_data_d    = rnd_data_q;
        busy_d        = busy_q;
        timeout_err_d = timeout_err_q;
        enter_shake   = 1'b0;
        exit_shake    = 1'b0;

        unique case (state_q)
            GEN: begin
                if (pend_q || req_shk) begin
                    enter_shake = 1'b1;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (step_cnt_q == STEP_LAST) begin
                        rnd_data_d  = lfsr_d;
                        rnd_valid_d = 1'b1;
                        step_cnt_d  = 4'd0;
                        state_d     = HOLD;
                    end else begin
                        step_cnt_d = step_cnt_q + 4'd1;
                    end
                end
            end

            HOLD: begin
                pend_d = pend_q | req_shk;
                if (rnd_ready) begin
                    rnd_valid_d = 1'b0;
                    if (pend_q || req_shk) begin
                        enter_shake = 1'b1;
                    end else begin
                        state_d = GEN;
                    end
                end
            end

            SHAKE: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // A result arriving on the last timeout cycle still counts as success.
                if (shk_end) begin
                    lfsr_d     = (shk_lfsr == '0) ? SEED_DEFAULT : shk_lfsr;
                    exit_shake = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    exit_shake    = 1'b1;
                end
            end

            default: state_d = GEN;
        endcase

        if (enter_shake) begin
            state_d    = SHAKE;
            step_cnt_d = 4'd0;
            pend_d     = 1'b0;
            tmo_cnt_d  = 16'd0;
            s_shk_d    = 1'b1;
            busy_d     = 1'b1;
        end

        if (exit_shake) begin
            state_d   = GEN;
            tmo_cnt_d = 16'd0;
            s_shk_d   = 1'b0;
            busy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q       <= GEN;
            lfsr_q        <= SEED_DEFAULT;
            step_cnt_q    <= 4'd0;
            pend_q        <= 1'b0;
            tmo_cnt_q     <= 16'd0;
            s_shk_q       <= 1'b0;
            rnd_valid_q   <= 1'b0;
            rnd_data_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            step_cnt_q    <= step_cnt_d;
            pend_q        <= pend_d;
            tmo_cnt_q     <= tmo_cnt_d;
            s_shk_q       <= s_shk_d;
            rnd_valid_q   <= rnd_valid_d;
            rnd_data_q    <= rnd_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign s_shk       = s_shk_q;
    assign curr_lfsr   = lfsr_q;
    assign rnd_valid   = rnd_valid_q;
    assign rnd_data    = rnd_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
